// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
//   Produces a lower-rate clock from i_clock using a phase accumulator, so the
//   average output frequency is exactly OUTPUT_RATE even when CLOCK_RATE is not
//   an integer multiple of it. Every toggle is half an output period. The
//   period-to-period jitter is at most one input cycle.
//
// Parameters (positional order: CLOCK_RATE, OUTPUT_RATE)
//   CLOCK_RATE  : input clock frequency in Hz (>= 2)
//   OUTPUT_RATE : o_clock frequency in Hz (1 <= OUTPUT_RATE, 2*OUTPUT_RATE <= CLOCK_RATE)
//
// Ports
//   i_clock : system clock (the only clock)
//   i_reset : synchronous, active-high reset
//   o_clock : divided clock, nominal 50% duty, driven straight from a flop
//   o_tick  : one-cycle strobe in the cycle o_clock first reads 1
// -----------------------------------------------------------------------------
module clock_divider #(
    parameter int CLOCK_RATE  = 50000000,
    parameter int OUTPUT_RATE = 9600
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_clock,
    output logic o_tick
);

    // One accumulator step equals half an output period expressed in Hz.
    localparam int INC   = 2 * OUTPUT_RATE;
    // One extra bit of headroom, so acc + INC never wraps.
    localparam int ACC_W = $clog2(CLOCK_RATE + INC) + 1;

    localparam logic [ACC_W-1:0] INC_C  = ACC_W'(INC);
    localparam logic [ACC_W-1:0] RATE_C = ACC_W'(CLOCK_RATE);

    // Reject parameter combinations that cannot produce the requested rate.
    if (CLOCK_RATE < 2 || OUTPUT_RATE < 1 || INC > CLOCK_RATE) begin : g_bad_params
        $error("clock_divider: illegal CLOCK_RATE/OUTPUT_RATE combination");
    end

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum_s;
    logic             clk_q;
    logic             clk_d;
    logic             tick_q;
    logic             tick_d;

    // Next-state logic: advance the phase and toggle when a half period has elapsed.
    always_comb begin
        sum_s  = acc_q + INC_C;
        acc_d  = sum_s;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (sum_s >= RATE_C) begin
            acc_d  = sum_s - RATE_C;
            clk_d  = ~clk_q;
            // Strobe only on the 0->1 transition.
            tick_d = ~clk_q;
        end else begin
            acc_d  = sum_s;
            clk_d  = clk_q;
            tick_d = 1'b0;
        end
    end

    // State registers. Reset wins over the accumulate step on the same edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign o_clock = clk_q;
    assign o_tick  = tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_clock_divider
//   Drives four clock_divider instances (10/1, 10/3, 8/4, 50M/153600) from a
//   shared clock and reset. The reference says that after n edges since reset
//   release the output has toggled floor(n*2*OUTPUT_RATE/CLOCK_RATE) times.
//   o_clock is the parity of that count. o_tick marks the edge where the count
//   steps to an odd value.
// -----------------------------------------------------------------------------
module tb_clock_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic ca, ta, cb, tb_t, cc, tc, ce, te;

    clock_divider #(10, 1)            u_a (.i_clock(clk), .i_reset(rst), .o_clock(ca), .o_tick(ta));
    clock_divider #(10, 3)            u_b (.i_clock(clk), .i_reset(rst), .o_clock(cb), .o_tick(tb_t));
    clock_divider #(8, 4)             u_c (.i_clock(clk), .i_reset(rst), .o_clock(cc), .o_tick(tc));
    clock_divider #(50000000, 153600) u_e (.i_clock(clk), .i_reset(rst), .o_clock(ce), .o_tick(te));

    int     n_checks = 0;
    int     n_err    = 0;
    longint n        = 0;   // edges since reset release

    // Bookkeeping for the toggle-count and half-period checks.
    int     a_ticks, b_toggles, b_ticks, e_ticks, e_halves;
    longint e_last;
    logic   prev_cb, prev_ce;

    function automatic longint toggles(input longint e, input longint cr, input longint orate);
        return (e * 2 * orate) / cr;
    endfunction

    function automatic logic exp_clk(input longint e, input longint cr, input longint orate);
        return (toggles(e, cr, orate) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input longint e, input longint cr, input longint orate);
        if (e == 0) return 1'b0;
        return (toggles(e, cr, orate) != toggles(e - 1, cr, orate)) && ((toggles(e, cr, orate) % 2) == 1);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one edge with reset level r, then compare every output with the model.
    task automatic step(input logic r);
        longint iv;
        rst = r;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else   n = n + 1;
        check_bit("a_clk",  ca,   exp_clk (n, 10, 1));
        check_bit("a_tick", ta,   exp_tick(n, 10, 1));
        check_bit("b_clk",  cb,   exp_clk (n, 10, 3));
        check_bit("b_tick", tb_t, exp_tick(n, 10, 3));
        check_bit("c_clk",  cc,   exp_clk (n, 8, 4));
        check_bit("c_tick", tc,   exp_tick(n, 8, 4));
        check_bit("e_clk",  ce,   exp_clk (n, 50000000, 153600));
        check_bit("e_tick", te,   exp_tick(n, 50000000, 153600));
        a_ticks += int'(ta);
        b_ticks += int'(tb_t);
        e_ticks += int'(te);
        if (cb !== prev_cb) b_toggles++;
        if (r) begin
            e_last = 0;
        end else if (ce !== prev_ce) begin
            iv = n - e_last;
            n_checks++;
            assert (iv == 162 || iv == 163) else begin
                n_err++;
                $error("FAIL e_half_period: observed=%0d expected=162 or 163", iv);
            end
            e_halves++;
            e_last = n;
        end
        prev_cb = cb;
        prev_ce = ce;
    endtask

    task automatic clear_counts();
        a_ticks   = 0;
        b_toggles = 0;
        b_ticks   = 0;
        e_ticks   = 0;
        e_halves  = 0;
    endtask

    initial begin
        prev_cb = 1'b0;
        prev_ce = 1'b0;
        e_last  = 0;
        clear_counts();

        // Reset held for 20 cycles: every output stays 0.
        repeat (20) step(1'b1);

        // 1000 cycles free-running from release.
        clear_counts();
        repeat (1000) step(1'b0);
        check_int("a_ticks_1000",   a_ticks,   100);
        check_int("b_toggles_1000", b_toggles, 600);
        check_int("b_ticks_1000",   b_ticks,   300);

        // Mid-operation reset at edge 7 after a fresh release.
        step(1'b1);
        repeat (6) step(1'b0);
        step(1'b1);
        check_bit("a_clk_after_midreset",  ca, 1'b0);
        check_bit("a_tick_after_midreset", ta, 1'b0);
        repeat (4) step(1'b0);
        check_bit("a_clk_before_rise", ca, 1'b0);
        step(1'b0);
        check_bit("a_clk_rise_5th",  ca, 1'b1);
        check_bit("a_tick_rise_5th", ta, 1'b1);

        // Random short resets sprinkled over normal operation.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        // Long run of the UART-rate instance: tick count and half-period bounds.
        step(1'b1);
        clear_counts();
        repeat (40000) step(1'b0);
        n_checks++;
        // 40000 cycles at 50 MHz is 0.8 ms, so 122.88 ticks are expected (within one).
        assert ((e_ticks * 64'd50000000 >= 64'd40000 * 64'd153600 - 64'd50000000) &&
                (e_ticks * 64'd50000000 <= 64'd40000 * 64'd153600 + 64'd50000000)) else begin
            n_err++;
            $error("FAIL e_tick_count: observed=%0d expected=122 or 123", e_ticks);
        end
        check_int("e_half_periods_seen", e_halves, 245);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
